// File: rtl/fifo_burst_pkg.sv
// Shared types and helpers for the burst-draining FIFO read controller.
package fifo_burst_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // A zero burst length still moves one beat; anything above max_len is clipped.
    function automatic int clamp_len(input int len, input int max_len);
        if (len == 0) return 1;
        if (len > max_len) return max_len;
        return len;
    endfunction

endpackage

// File: rtl/out_reg_slice.sv
// One-entry valid/ready output register carrying a payload and a last marker.
module out_reg_slice #(
    parameter type data_t = logic
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  data_t load_data,
    input  logic  load_last,
    output logic  slot_free,
    output logic  valid,
    output data_t data,
    output logic  last,
    input  logic  ready
);

    assign slot_free = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load && slot_free) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_burst_drain.sv
// Pops a fall-through FIFO in bursts onto a registered valid/ready stream,
// flushing partial bursts after an idle timeout.
//
//   state | meaning
//   IDLE  | waiting for a full burst or an expired idle timer
//   BURST | popping until the sampled beat count is exhausted
module fifo_burst_drain
    import fifo_burst_pkg::*;
#(
    parameter type data_t   = logic,
    parameter int  CntWidth = 1,
    parameter int  MaxBurst = 16,
    parameter int  BurstW   = $clog2(MaxBurst + 1),
    parameter int  TimeoutW = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fifo_empty,
    input  data_t               fifo_dout,
    input  logic [CntWidth-1:0] fifo_cnt,
    output logic                fifo_pop,
    input  logic [BurstW-1:0]   burst_len,
    input  logic [TimeoutW-1:0] timeout,
    output logic                out_valid,
    input  logic                out_ready,
    output data_t               out_data,
    output logic                out_last,
    output logic                busy
);

    localparam int CmpW = (CntWidth > BurstW) ? CntWidth : BurstW;

    state_t              state;
    logic [BurstW-1:0]   beats_left;
    logic [TimeoutW-1:0] timer;

    logic [BurstW-1:0] eff_len;
    logic [BurstW-1:0] flush_len;
    logic [CmpW-1:0]   cnt_ext;
    logic [CmpW-1:0]   len_ext;
    logic              full_ready;
    logic              flush_ready;
    logic              slot_free;

    assign eff_len = BurstW'(clamp_len(int'(burst_len), MaxBurst));
    assign cnt_ext = CmpW'(fifo_cnt);
    assign len_ext = CmpW'(eff_len);

    assign full_ready  = cnt_ext >= len_ext;
    assign flush_ready = (timeout != '0) && (timer >= timeout) && !fifo_empty;
    assign flush_len   = (cnt_ext < len_ext) ? BurstW'(cnt_ext) : eff_len;

    assign fifo_pop = !reset && (state == BURST) && !fifo_empty
                      && (beats_left != '0) && slot_free;
    assign busy     = (state == BURST) || out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beats_left <= '0;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_empty)
                        timer <= '0;
                    else if (timer != '1)
                        timer <= timer + TimeoutW'(1);
                    // A full burst wins over a timeout flush.
                    if (full_ready) begin
                        state      <= BURST;
                        beats_left <= eff_len;
                    end else if (flush_ready) begin
                        state      <= BURST;
                        beats_left <= flush_len;
                    end
                end
                BURST: begin
                    if (fifo_pop) begin
                        beats_left <= beats_left - BurstW'(1);
                        if (beats_left == BurstW'(1)) begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    out_reg_slice #(.data_t(data_t)) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (fifo_pop),
        .load_data (fifo_dout),
        .load_last (beats_left == BurstW'(1)),
        .slot_free (slot_free),
        .valid     (out_valid),
        .data      (out_data),
        .last      (out_last),
        .ready     (out_ready)
    );

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: a queue stands in for the FIFO, a cycle model of
// the burst rules predicts pops and output beats, and streams are checked end to end.
module tb_fifo_burst_drain;

    localparam int CntWidth = 6;
    localparam int MaxBurst = 16;
    localparam int BurstW   = 5;
    localparam int TimeoutW = 8;

    typedef logic [7:0] data_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                fifo_empty;
    data_t               fifo_dout;
    logic [CntWidth-1:0] fifo_cnt;
    logic                fifo_pop;
    logic [BurstW-1:0]   burst_len;
    logic [TimeoutW-1:0] timeout;
    logic                out_valid;
    logic                out_ready;
    data_t               out_data;
    logic                out_last;
    logic                busy;

    int total = 0;
    int bad   = 0;

    data_t fq[$];
    data_t pushed[$];
    data_t got_data[$];
    bit    got_last[$];
    int    pop_cnt;
    data_t next_val = 8'd1;

    bit    m_burst;
    int    m_rem;
    int    m_wait;
    bit    m_valid;
    data_t m_data;
    bit    m_last;

    fifo_burst_drain #(
        .data_t   (data_t),
        .CntWidth (CntWidth),
        .MaxBurst (MaxBurst),
        .TimeoutW (TimeoutW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_cnt   (fifo_cnt),
        .fifo_pop   (fifo_pop),
        .burst_len  (burst_len),
        .timeout    (timeout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_lasts();
        int n = 0;
        foreach (got_last[i]) n += int'(got_last[i]);
        return n;
    endfunction

    function automatic int first_last();
        foreach (got_last[i]) if (got_last[i]) return i;
        return -1;
    endfunction

    // One clock: present FIFO state, predict and check, then advance model and FIFO.
    task automatic cycle(input bit do_push);
        int cnt;
        int eff;
        bit exp_pop;
        bit was_burst;
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fq[0];
        fifo_cnt   = CntWidth'(fq.size());
        #1;
        cnt = fq.size();
        eff = (burst_len == 0) ? 1 : ((int'(burst_len) > MaxBurst) ? MaxBurst : int'(burst_len));
        exp_pop = !reset && m_burst && cnt > 0 && m_rem > 0 && (!m_valid || out_ready);

        chk("fifo_pop", fifo_pop, exp_pop);
        chk("out_valid", out_valid, m_valid);
        chk("busy", busy, m_burst || m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_last", out_last, m_last);
        end

        if (fifo_pop) pop_cnt++;
        if (!reset && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end

        was_burst = m_burst;
        if (reset) begin
            m_burst = 0; m_rem = 0; m_wait = 0;
            m_valid = 0; m_data = '0; m_last = 0;
        end else begin
            if (exp_pop) begin
                m_data  = fq[0];
                m_last  = (m_rem == 1);
                m_valid = 1;
                m_rem--;
                if (m_rem == 0) begin
                    m_burst = 0;
                    m_wait  = 0;
                end
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (!was_burst) begin
                if (cnt >= eff) begin
                    m_burst = 1;
                    m_rem   = eff;
                end else if (timeout != 0 && m_wait >= int'(timeout) && cnt > 0) begin
                    m_burst = 1;
                    m_rem   = cnt;
                end
                m_wait = (cnt > 0) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
            end
        end

        if (fifo_pop && fq.size() > 0) void'(fq.pop_front());
        if (do_push) begin
            fq.push_back(next_val);
            pushed.push_back(next_val);
            next_val++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, " count"}, got_data.size(), pushed.size());
        for (int i = 0; i < got_data.size() && i < pushed.size(); i++)
            chk({tag, " beat"}, got_data[i], pushed[i]);
        got_data.delete();
        got_last.delete();
        pushed.delete();
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b1; burst_len = 5'd4; timeout = '0;
        fifo_empty = 1'b1; fifo_dout = '0; fifo_cnt = '0; pop_cnt = 0;
        m_burst = 0; m_rem = 0; m_wait = 0; m_valid = 0; m_data = '0; m_last = 0;
        @(negedge clk);
        cycle(0);
        cycle(0);
        reset = 1'b0;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_last", out_last, 0);
        chk("reset busy", busy, 0);

        // full bursts of 4
        pop_cnt = 0;
        repeat (8) cycle(1);
        repeat (12) cycle(0);
        chk("full pops", pop_cnt, 8);
        chk("full lasts", count_lasts(), 2);
        if (got_last.size() == 8) chk("full last pos", {got_last[3], got_last[7]}, 2'b11);
        check_stream("full");

        // partial flush after the idle timeout
        timeout = 8'd5;
        repeat (2) cycle(1);
        repeat (15) cycle(0);
        chk("flush lasts", count_lasts(), 1);
        if (got_last.size() == 2) chk("flush last pos", got_last[1], 1);
        check_stream("flush");

        // backpressure mid-burst
        timeout = '0;
        repeat (4) cycle(1);
        for (int i = 0; i < 20 && got_data.size() == 0; i++) cycle(0);
        chk("bp first beat seen", got_data.size() > 0, 1);
        out_ready = 1'b0;
        repeat (3) cycle(0);
        out_ready = 1'b1;
        repeat (10) cycle(0);
        check_stream("bp");

        // burst_len sampled at burst start; late entries wait for a flush
        repeat (4) cycle(1);
        cycle(0);
        burst_len = 5'd8;
        repeat (6) begin
            out_ready = ($urandom_range(0, 1) == 1);
            cycle(0);
        end
        out_ready = 1'b1;
        repeat (3) cycle(1);
        repeat (10) cycle(0);
        chk("sample beats", got_data.size(), 4);
        chk("sample lasts", count_lasts(), 1);
        timeout = 8'd2;
        repeat (12) cycle(0);
        check_stream("sample");

        // burst_len 0 gives single-beat bursts
        burst_len = '0; timeout = '0;
        repeat (3) cycle(1);
        repeat (10) cycle(0);
        chk("len0 lasts", count_lasts(), 3);
        check_stream("len0");

        // reset mid-burst
        burst_len = 5'd4;
        repeat (4) cycle(1);
        for (int i = 0; i < 20 && got_data.size() < 2; i++) cycle(0);
        reset = 1'b1;
        cycle(0);
        reset = 1'b0;
        fq.delete();
        chk("midrst out_valid", out_valid, 0);
        chk("midrst fifo_pop", fifo_pop, 0);
        chk("midrst busy", busy, 0);
        got_data.delete(); got_last.delete(); pushed.delete();
        timeout = 8'd3;
        cycle(1);
        repeat (10) cycle(0);
        check_stream("post reset");

        // clamp to MaxBurst
        burst_len = 5'd19; timeout = '0;
        repeat (20) cycle(1);
        repeat (25) cycle(0);
        chk("clamp first burst", first_last() + 1, MaxBurst);
        timeout = 8'd2;
        repeat (15) cycle(0);
        check_stream("clamp");

        // randomized traffic
        repeat (400) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) burst_len = BurstW'($urandom_range(0, 20));
            timeout = TimeoutW'($urandom_range(0, 6));
            cycle(($urandom_range(0, 2) == 0) && fq.size() < 60);
        end
        burst_len = 5'd1; timeout = 8'd1; out_ready = 1'b1;
        repeat (80) cycle(0);
        check_stream("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
